disp_scan_decoder: RTL and testbench

DISP_SCAN_DECODER -- requirements
Module: disp_scan_decoder

---
 rtl/disp_pkg.sv | 39 +++
 rtl/seg_decode.sv | 28 ++
 rtl/disp_scan_decoder.sv | 160 ++++++++++++++++
 tb/tb_disp_scan_decoder.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// Shared display constants: one-cold anode selects, active-low segment patterns, digit codes
// and the scan-decoder FSM state type.
package disp_pkg;

  localparam logic [3:0] AnodeD1    = 4'b0111;
  localparam logic [3:0] AnodeD2    = 4'b1011;
  localparam logic [3:0] AnodeD3    = 4'b1101;
  localparam logic [3:0] AnodeD4    = 4'b1110;
  localparam logic [3:0] AnodeBlank = 4'b1111;

  localparam logic [6:0] Seg0     = 7'b1000000;
  localparam logic [6:0] Seg1     = 7'b1111001;
  localparam logic [6:0] Seg2     = 7'b0100100;  // also what the driver emits for code 6
  localparam logic [6:0] Seg4     = 7'b0001100;
  localparam logic [6:0] Seg5     = 7'b0101111;
  localparam logic [6:0] Seg8     = 7'b0111111;
  localparam logic [6:0] SegBlank = 7'b1111111;

  localparam logic [3:0] Code0     = 4'b0000;
  localparam logic [3:0] Code1     = 4'b0001;
  localparam logic [3:0] Code2     = 4'b0010;
  localparam logic [3:0] Code4     = 4'b0100;
  localparam logic [3:0] Code5     = 4'b0101;
  localparam logic [3:0] Code8     = 4'b1000;
  localparam logic [3:0] CodeBlank = 4'b1111;
  localparam logic [3:0] CodeBad   = 4'b1011;

  typedef enum logic [1:0] {
    StSync,
    StGot1,
    StGot2,
    StGot3
  } state_e;

  function automatic logic anode_is_digit(logic [3:0] anode);
    return (anode == AnodeD1) || (anode == AnodeD2) || (anode == AnodeD3) || (anode == AnodeD4);
  endfunction

endpackage

// File: rtl/seg_decode.sv
// Combinational segment-pattern to digit-code decoder; unknown patterns yield CodeBad.
module seg_decode
  import disp_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] code,
  output logic       invalid
);

  always_comb begin
    code    = CodeBad;
    invalid = 1'b0;
    case (seg)
      Seg0:     code = Code0;
      Seg1:     code = Code1;
      Seg2:     code = Code2;
      Seg4:     code = Code4;
      Seg5:     code = Code5;
      Seg8:     code = Code8;
      SegBlank: code = CodeBlank;
      default: begin
        code    = CodeBad;
        invalid = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/disp_scan_decoder.sv
// Recovers the four digits shown by a multiplexed 7-segment driver by watching its anode and
// segment lines, publishing each complete in-order frame.
module disp_scan_decoder
  import disp_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] Anode,
  input  logic [6:0] leds,
  output logic [3:0] d1,
  output logic [3:0] d2,
  output logic [3:0] d3,
  output logic [3:0] d4,
  output logic       frame_valid,
  output logic       pattern_err,
  output logic       seq_err
);

  localparam logic [3:0] StableMax = 4'(STABLE_CYCLES);

  logic [3:0] anode_q, last_q, last_d, cnt_q, cnt_d;
  logic [6:0] leds_q;
  state_e     state_q, state_d;
  logic [3:0] s1_q, s2_q, s3_q, s1_d, s2_d, s3_d;
  logic [3:0] d1_q, d2_q, d3_q, d4_q, d1_d, d2_d, d3_d, d4_d;
  logic       fv_q, pe_q, se_q, fv_d, pe_d, se_d;
  logic [3:0] code;
  logic       invalid;
  logic       fresh;

  seg_decode u_seg_decode (
    .seg     (leds_q),
    .code    (code),
    .invalid (invalid)
  );

  // Counter tracks how long the incoming sample has matched the one already registered.
  always_comb begin
    cnt_d = cnt_q;
    if ({Anode, leds} != {anode_q, leds_q}) begin
      cnt_d = 4'd1;
    end else if (cnt_q < StableMax) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  assign fresh = (cnt_q == StableMax) && (anode_q != AnodeBlank) && (anode_q != last_q);

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    s3_d    = s3_q;
    d1_d    = d1_q;
    d2_d    = d2_q;
    d3_d    = d3_q;
    d4_d    = d4_q;
    fv_d    = 1'b0;
    pe_d    = 1'b0;
    se_d    = 1'b0;
    if (fresh) begin
      last_d = anode_q;
      if (!anode_is_digit(anode_q)) begin
        se_d    = 1'b1;
        state_d = StSync;
      end else begin
        pe_d = invalid;
        if (anode_q == AnodeD1) begin
          // Leftmost digit always (re)starts a frame; it is only an error mid-frame.
          s1_d    = code;
          state_d = StGot1;
          se_d    = (state_q != StSync);
        end else begin
          case (state_q)
            StSync: state_d = StSync;
            StGot1: begin
              if (anode_q == AnodeD2) begin
                s2_d    = code;
                state_d = StGot2;
              end else begin
                se_d    = 1'b1;
                state_d = StSync;
              end
            end
            StGot2: begin
              if (anode_q == AnodeD3) begin
                s3_d    = code;
                state_d = StGot3;
              end else begin
                se_d    = 1'b1;
                state_d = StSync;
              end
            end
            StGot3: begin
              state_d = StSync;
              if (anode_q == AnodeD4) begin
                d1_d = s1_q;
                d2_d = s2_q;
                d3_d = s3_q;
                d4_d = code;
                fv_d = 1'b1;
              end else begin
                se_d = 1'b1;
              end
            end
            default: state_d = StSync;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      anode_q <= AnodeBlank;
      leds_q  <= SegBlank;
      cnt_q   <= 4'd0;
      last_q  <= AnodeBlank;
      state_q <= StSync;
      s1_q    <= CodeBlank;
      s2_q    <= CodeBlank;
      s3_q    <= CodeBlank;
      d1_q    <= CodeBlank;
      d2_q    <= CodeBlank;
      d3_q    <= CodeBlank;
      d4_q    <= CodeBlank;
      fv_q    <= 1'b0;
      pe_q    <= 1'b0;
      se_q    <= 1'b0;
    end else begin
      anode_q <= Anode;
      leds_q  <= leds;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      state_q <= state_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      s3_q    <= s3_d;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
      d3_q    <= d3_d;
      d4_q    <= d4_d;
      fv_q    <= fv_d;
      pe_q    <= pe_d;
      se_q    <= se_d;
    end
  end

  assign d1          = d1_q;
  assign d2          = d2_q;
  assign d3          = d3_q;
  assign d4          = d4_q;
  assign frame_valid = fv_q;
  assign pattern_err = pe_q;
  assign seq_err     = se_q;

endmodule

// File: tb/tb_disp_scan_decoder.sv
// Bench for disp_scan_decoder: two instances (STABLE_CYCLES 1 and 3) share one input stream
// and are each compared every cycle against a frame-level reference model.
module tb_disp_scan_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] anode = 4'hF;
  logic [6:0] leds = 7'h7F;

  logic [3:0] a_d1, a_d2, a_d3, a_d4, b_d1, b_d2, b_d3, b_d4;
  logic       a_fv, a_pe, a_se, b_fv, b_pe, b_se;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  disp_scan_decoder #(.STABLE_CYCLES(1)) dut_a (
    .clk(clk), .rst(rst), .Anode(anode), .leds(leds),
    .d1(a_d1), .d2(a_d2), .d3(a_d3), .d4(a_d4),
    .frame_valid(a_fv), .pattern_err(a_pe), .seq_err(a_se)
  );

  disp_scan_decoder #(.STABLE_CYCLES(3)) dut_b (
    .clk(clk), .rst(rst), .Anode(anode), .leds(leds),
    .d1(b_d1), .d2(b_d2), .d3(b_d3), .d4(b_d4),
    .frame_valid(b_fv), .pattern_err(b_pe), .seq_err(b_se)
  );

  // Reference model state, one slot per instance.
  int         sc[2] = '{1, 3};
  logic [3:0] hist_a[$];
  logic [6:0] hist_l[$];
  logic [3:0] m_last[2];
  int         m_qlen[2];
  logic [3:0] m_sh[2][3];
  logic [15:0] m_pub[2];
  logic       m_fv[2], m_pe[2], m_se[2];
  int         n_frames[2];

  function automatic logic [4:0] ref_decode(input logic [6:0] s);
    case (s)
      7'b1000000: return {1'b0, 4'h0};
      7'b1111001: return {1'b0, 4'h1};
      7'b0100100: return {1'b0, 4'h2};
      7'b0001100: return {1'b0, 4'h4};
      7'b0101111: return {1'b0, 4'h5};
      7'b0111111: return {1'b0, 4'h8};
      7'b1111111: return {1'b0, 4'hF};
      default:    return {1'b1, 4'hB};
    endcase
  endfunction

  function automatic logic [6:0] enc(input logic [3:0] c);
    case (c)
      4'h0:    return 7'b1000000;
      4'h1:    return 7'b1111001;
      4'h2:    return 7'b0100100;
      4'h4:    return 7'b0001100;
      4'h5:    return 7'b0101111;
      4'h8:    return 7'b0111111;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic int pos_of(input logic [3:0] a);
    case (a)
      4'b0111: return 0;
      4'b1011: return 1;
      4'b1101: return 2;
      4'b1110: return 3;
      default: return -1;
    endcase
  endfunction

  task automatic model_reset();
    hist_a.delete();
    hist_l.delete();
    for (int k = 0; k < 2; k++) begin
      m_last[k] = 4'hF;
      m_qlen[k] = 0;
      m_pub[k]  = 16'hFFFF;
      m_fv[k]   = 1'b0;
      m_pe[k]   = 1'b0;
      m_se[k]   = 1'b0;
    end
  endtask

  // Judges the most recently registered input; its effect is visible after the next edge.
  task automatic model_decide(input int k);
    int n, run, p;
    logic [3:0] a;
    logic [6:0] l;
    logic [4:0] dec;
    m_fv[k] = 1'b0;
    m_pe[k] = 1'b0;
    m_se[k] = 1'b0;
    n = hist_a.size();
    if (n == 0) return;
    a = hist_a[n-1];
    l = hist_l[n-1];
    run = 1;
    for (int j = n - 2; j >= 0 && run < sc[k]; j--) begin
      if (hist_a[j] != a || hist_l[j] != l) break;
      run++;
    end
    if (run < sc[k] || a == 4'hF || a == m_last[k]) return;
    m_last[k] = a;
    p = pos_of(a);
    if (p < 0) begin
      m_se[k]   = 1'b1;
      m_qlen[k] = 0;
      return;
    end
    dec = ref_decode(l);
    m_pe[k] = dec[4];
    if (p == 0) begin
      m_se[k]     = (m_qlen[k] != 0);
      m_sh[k][0]  = dec[3:0];
      m_qlen[k]   = 1;
    end else if (m_qlen[k] == p) begin
      if (p == 3) begin
        m_pub[k]  = {m_sh[k][0], m_sh[k][1], m_sh[k][2], dec[3:0]};
        m_fv[k]   = 1'b1;
        m_qlen[k] = 0;
        n_frames[k]++;
      end else begin
        m_sh[k][p] = dec[3:0];
        m_qlen[k]  = p + 1;
      end
    end else if (m_qlen[k] != 0) begin
      m_se[k]   = 1'b1;
      m_qlen[k] = 0;
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("A digits", {a_d1, a_d2, a_d3, a_d4}, m_pub[0]);
    chk("A frame_valid", 16'(a_fv), 16'(m_fv[0]));
    chk("A pattern_err", 16'(a_pe), 16'(m_pe[0]));
    chk("A seq_err", 16'(a_se), 16'(m_se[0]));
    chk("B digits", {b_d1, b_d2, b_d3, b_d4}, m_pub[1]);
    chk("B frame_valid", 16'(b_fv), 16'(m_fv[1]));
    chk("B pattern_err", 16'(b_pe), 16'(m_pe[1]));
    chk("B seq_err", 16'(b_se), 16'(m_se[1]));
  endtask

  task automatic step(input logic [3:0] a, input logic [6:0] l);
    model_decide(0);
    model_decide(1);
    anode = a;
    leds  = l;
    hist_a.push_back(a);
    hist_l.push_back(l);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    anode = 4'hF;
    leds  = 7'h7F;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    check_all();
  endtask

  task automatic digit(input logic [3:0] a, input logic [3:0] c, input int hold);
    repeat (hold) step(a, enc(c));
  endtask

  task automatic frame(input logic [15:0] c, input int hold);
    digit(4'b0111, c[15:12], hold);
    digit(4'b1011, c[11:8], hold);
    digit(4'b1101, c[7:4], hold);
    digit(4'b1110, c[3:0], hold);
  endtask

  logic [3:0] codes[7] = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'h8, 4'hF};
  logic [3:0] anodes[4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

  initial begin
    int f0, hold;
    logic [3:0] a;
    logic [6:0] l;
    n_frames = '{0, 0};
    model_reset();
    do_reset();
    repeat (2) step(4'hF, 7'h7F);

    // Loopback driver, one digit per clock: a frame every 4 cycles on the fast instance.
    f0 = n_frames[0];
    repeat (4) frame(16'h4128, 1);
    step(4'hF, 7'h7F);
    chk("loopback frame count", 16'(n_frames[0] - f0), 16'd4);

    // Single frame; d4 shows up on the outputs two cycles after it is applied.
    repeat (3) step(4'hF, 7'h7F);
    frame(16'h0158, 1);
    repeat (2) step(4'hF, 7'h7F);

    // Unmapped segment pattern on digit 2.
    digit(4'b0111, 4'h1, 3);
    repeat (3) step(4'b1011, 7'b0111110);
    digit(4'b1101, 4'h2, 3);
    digit(4'b1110, 4'h4, 3);
    repeat (3) step(4'hF, 7'h7F);

    // Out-of-order digit.
    digit(4'b0111, 4'h5, 3);
    digit(4'b1101, 4'h5, 3);
    repeat (3) step(4'hF, 7'h7F);

    // Illegal anode, then blanking between digits of a good frame.
    repeat (3) step(4'b0011, enc(4'h1));
    for (int i = 0; i < 4; i++) begin
      digit(anodes[i], codes[i], 3);
      repeat (2) step(4'hF, 7'h7F);
    end

    // Slow instance: 2-cycle holds never accepted, 3-cycle holds accepted once each.
    f0 = n_frames[1];
    frame(16'h8421, 2);
    step(4'hF, 7'h7F);
    chk("hold2 frame count", 16'(n_frames[1] - f0), 16'd0);
    frame(16'h8421, 3);
    step(4'hF, 7'h7F);
    chk("hold3 frame count", 16'(n_frames[1] - f0), 16'd1);

    // Reset while collecting digit 3, then a clean frame.
    digit(4'b0111, 4'h0, 3);
    digit(4'b1011, 4'h1, 3);
    step(4'b1101, enc(4'h2));
    do_reset();
    frame(16'h5280, 3);
    repeat (2) step(4'hF, 7'h7F);

    // Randomised driver with occasional glitches, skips, blanks and resets.
    for (int fr = 0; fr < 120; fr++) begin
      hold = $urandom_range(1, 4);
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 11) == 0) continue;
        a = ($urandom_range(0, 11) == 0) ? 4'($urandom_range(0, 15)) : anodes[i];
        l = ($urandom_range(0, 9) == 0) ? 7'($urandom_range(0, 127))
                                        : enc(codes[$urandom_range(0, 6)]);
        repeat (hold) step(a, l);
        if ($urandom_range(0, 7) == 0) step(4'hF, 7'h7F);
      end
      if ($urandom_range(0, 39) == 0) do_reset();
    end
    repeat (4) step(4'hF, 7'h7F);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

endmodule
